fconv_sched: RTL and testbench
==============================

# fconv_sched

Issue scheduler for the shared integer-to-float conversion unit in the FPU. Two requesters (integer pipe = port 0, FP pipe = port 1) compete for one fixed-latency converter through valid/ready handshakes. The block tracks in-flight operations with their tag and source, and buffers results in a small FIFO so a stalled consumer never drops a conversion. It sits between the issue stage and the converter and owns all flow control around it.

## Interface
Parameters:
- `TAG_W`, default 4: width of the requester tag carried alongside each operation.
- `LAT`, default 1: converter latency in clock edges, from `cv_x` being sampled to the matching `cv_y`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: port 0 request.
- `req0_ready` out 1: port 0 accepted this cycle.
- `req0_x` in 32: port 0 two's-complement integer.
- `req0_tag` in TAG_W: port 0 tag.
- `req1_valid`, `req1_ready`, `req1_x`, `req1_tag`: same as port 0, for port 1.
- `cv_x` out 32: operand to the converter.
- `cv_y` in 32: converter result, valid exactly LAT edges after issue.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_y` out 32: IEEE-754 single result.
- `rsp_tag` out TAG_W: tag of the result.
- `rsp_src` out 1: originating port (0 or 1).

## Operation
- Localparam `DEPTH = LAT + 2` sets the result FIFO entry count.
- Credit: issue is allowed when `inflight + fifo_count < DEPTH`.
  - `inflight` is the number of valid pipe stages.
  - The check uses registered state only, so there is no combinational path from `rsp_ready` to `reqN_ready`.
- Grant: `reqN_ready = reqN_valid & credit & arbiter_select(N)`.
  - At most one grant per cycle.
  - `reqN_ready` may depend on `reqN_valid`. Requesters must not make valid depend on ready.
- `cv_x` is the granted port's operand, or 32'h0 when there is no grant.
- Tracking pipe: LAT stages of {valid, tag, src}.
  - Stage 0 loads the grant on each edge.
  - When the last stage is valid, the FIFO writes {`cv_y`, tag, src} on the next edge.
- FIFO:
  - Pointer-based with a count from 0 to DEPTH; pointers wrap modulo DEPTH.
  - Pop on `rsp_valid & rsp_ready`.
  - Simultaneous push and pop keeps the count unchanged.
  - Credit guarantees no push while full. Verification asserts this.
- `rsp_valid = (fifo_count != 0)`. `rsp_y`, `rsp_tag` and `rsp_src` show the head entry and hold stable while `rsp_valid & !rsp_ready`.
- Results return strictly in issue order.
- Reset effects:
  - Pipe valids, FIFO pointers, count and the arbiter pointer are cleared.
  - `rsp_valid`, `req0_ready` and `req1_ready` are 0, and `cv_x` is 0, during and after reset until the next request.
  - Reset mid-operation discards all in-flight and buffered results; no result appears for them.

## Timing
- A request accepted at edge E appears with `rsp_valid` high in the cycle after edge E+LAT. Minimum latency is LAT+1 cycles.
- With `rsp_ready` held at 1, throughput is one result per cycle sustained.
- With `rsp_ready` held at 0, at most DEPTH requests are accepted. Afterwards both readies are 0 until a pop frees credit; one issue is possible per edge after that pop.
- A request arriving in the first cycle after reset deasserts is eligible for grant in that same cycle.

## Configuration
- `FCONV_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port.
  - After any grant, the pointer moves to the other port.
  - When both ports are valid, the preferred port wins.
  - The pointer resets to 0.
- `FCONV_RR_EN` undefined: fixed priority, port 0 always wins. There is no pointer register.

## Structure
- Shared FPU package holds:
  - `FCONV_SRC_INT = 1'b0` and `FCONV_SRC_FP = 1'b1`.
  - The default tag width constant.
  - A packed struct for a FIFO entry {y, tag, src}.
- One sub-module, `fconv_rsp_fifo`: parameterized depth, push/pop, count output, no overflow protection of its own.

## Test plan
- Single issue, LAT=1: `req0_x` = 32'd5, tag 3 → `rsp_y` = 32'h40A00000, `rsp_tag` = 3, `rsp_src` = 0, `rsp_valid` two cycles after accept.
- Both ports valid each cycle, `rsp_ready` = 1: port 0 sends -1, port 1 sends 1.
  - With `FCONV_RR_EN`: alternating grants, responses 32'hBF800000 and 32'h3F800000 in issue order, one per cycle.
  - Without `FCONV_RR_EN`: port 1 is starved while port 0 stays valid.
- Backpressure: `rsp_ready` = 0 with 6 queued requests → exactly DEPTH = 3 accepted. Raise `rsp_ready` → results drain in order, then the remaining requests issue; no loss, no duplication.
- Boundary values: 32'h80000000 → 32'hCF000000; 0 → 32'h00000000; 32'h7FFFFFFF → 32'h4F000000.
- Reset mid-stream: reset while 2 results are buffered and 1 is in flight → `rsp_valid` = 0 the cycle after; no stale results appear after the next fresh request's result.
- Response hold: `rsp_valid` high, `rsp_ready` low for 5 cycles → `rsp_y`, `rsp_tag` and `rsp_src` remain constant.

Source files
------------

// File: rtl/fconv_sched_pkg.sv
// Shared FPU definitions for the int-to-float conversion scheduler.
package fconv_sched_pkg;

    localparam logic FCONV_SRC_INT = 1'b0;
    localparam logic FCONV_SRC_FP  = 1'b1;
    localparam int   FCONV_TAG_W   = 4;

    typedef struct packed {
        logic [31:0]            y;
        logic [FCONV_TAG_W-1:0] tag;
        logic                   src;
    } fconv_entry_t;

endpackage

// File: rtl/fconv_sched_if.sv
// Request, converter and response signals of the conversion scheduler.
interface fconv_sched_if
    import fconv_sched_pkg::*;
#(
    parameter int TAG_W = FCONV_TAG_W
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_x;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_x;
    logic [TAG_W-1:0] req1_tag;
    logic [31:0]      cv_x;
    logic [31:0]      cv_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_y;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_src;

    modport slave (
        input  req0_valid, req0_x, req0_tag,
        input  req1_valid, req1_x, req1_tag,
        input  cv_y, rsp_ready,
        output req0_ready, req1_ready, cv_x,
        output rsp_valid, rsp_y, rsp_tag, rsp_src
    );

    modport master (
        output req0_valid, req0_x, req0_tag,
        output req1_valid, req1_x, req1_tag,
        output cv_y, rsp_ready,
        input  req0_ready, req1_ready, cv_x,
        input  rsp_valid, rsp_y, rsp_tag, rsp_src
    );

endinterface

// File: rtl/fconv_rsp_fifo.sv
// Result FIFO for the conversion scheduler; overflow is prevented upstream.
module fconv_rsp_fifo
    import fconv_sched_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int W     = $bits(fconv_entry_t),
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wptr_d  = push_i ? nxt(wptr_q) : wptr_q;
        rptr_d  = pop_i ? nxt(rptr_q) : rptr_q;
        count_d = count_q;
        if (push_i && !pop_i) count_d = count_q + 1'b1;
        if (!push_i && pop_i) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q];
    assign count_o = count_q;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(push_i && count_q == CW'(DEPTH))
    );

endmodule

// File: rtl/fconv_sched.sv
// Issue scheduler for the shared int-to-float converter.
// Define FCONV_RR_EN for round-robin arbitration; fixed priority otherwise.
module fconv_sched
    import fconv_sched_pkg::*;
#(
    parameter int TAG_W = FCONV_TAG_W,
    parameter int LAT   = 1
) (
    input logic          clk,
    input logic          rst,
    fconv_sched_if.slave bus
);

    localparam int DEPTH = LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int EW    = 32 + TAG_W + 1;

    logic [LAT-1:0]            v_q, v_d;
    logic [LAT-1:0]            src_q, src_d;
    logic [LAT-1:0][TAG_W-1:0] tag_q, tag_d;

    logic [CW-1:0] cnt;
    logic [CW:0]   inflight;
    logic          credit;
    logic          sel1;
    logic          gnt0, gnt1;
    logic          rsp_vld;
    logic          push, pop;
    logic [EW-1:0] din, dout;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++)
            inflight = inflight + (CW+1)'(v_q[i]);
    end

    // Registered state only: rsp_ready never reaches the request readies.
    assign credit = !rst &&
        ((inflight + {1'b0, cnt}) < (CW+1)'(DEPTH));

`ifdef FCONV_RR_EN
    logic rr_q, rr_d;

    assign sel1 = bus.req1_valid &
        (!bus.req0_valid | rr_q);
    assign rr_d = (gnt0 | gnt1) ? gnt0 : rr_q;

    always_ff @(posedge clk) begin
        if (rst) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end
`else
    assign sel1 = bus.req1_valid & !bus.req0_valid;
`endif

    assign gnt1 = credit & sel1;
    assign gnt0 = credit & bus.req0_valid & !sel1;

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.cv_x = gnt0 ? bus.req0_x :
                      gnt1 ? bus.req1_x : 32'h0;

    always_comb begin
        v_d[0]   = gnt0 | gnt1;
        tag_d[0] = gnt1 ? bus.req1_tag : bus.req0_tag;
        src_d[0] = gnt1 ? FCONV_SRC_FP : FCONV_SRC_INT;
        for (int i = 1; i < LAT; i++) begin
            v_d[i]   = v_q[i-1];
            tag_d[i] = tag_q[i-1];
            src_d[i] = src_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            tag_q <= '0;
            src_q <= '0;
        end else begin
            v_q   <= v_d;
            tag_q <= tag_d;
            src_q <= src_d;
        end
    end

    assign push = v_q[LAT-1];
    assign din  = {bus.cv_y, tag_q[LAT-1], src_q[LAT-1]};

    assign rsp_vld = !rst && (cnt != '0);
    assign pop     = rsp_vld & bus.rsp_ready;

    fconv_rsp_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (din),
        .pop_i   (pop),
        .dout_o  (dout),
        .count_o (cnt)
    );

    assign bus.rsp_valid = rsp_vld;
    assign bus.rsp_y     = dout[EW-1 -: 32];
    assign bus.rsp_tag   = dout[TAG_W:1];
    assign bus.rsp_src   = dout[0];

endmodule

// File: tb/tb_fconv_sched.sv
// Self-checking bench for fconv_sched with a behavioural converter model.
module tb_fconv_sched;
    import fconv_sched_pkg::*;

    localparam int LAT = 1;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  tag;
        logic        src;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [31:0] cvp [LAT];

    fconv_sched_if #(.TAG_W(4)) bus ();

    fconv_sched #(.TAG_W(4), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] int2f(input logic [31:0] x);
        logic        s;
        logic [31:0] m, mant, rem, half;
        logic [7:0]  e;
        int          p, sh;
        if (x == 32'h0) return 32'h0;
        s = x[31];
        m = s ? -x : x;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        e = 8'(127 + p);
        if (p <= 23) begin
            mant = m << (23 - p);
        end else begin
            sh   = p - 23;
            mant = m >> sh;
            rem  = m & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0]))
                mant = mant + 32'd1;
            if (mant[24]) begin
                mant = mant >> 1;
                e    = e + 8'd1;
            end
        end
        return {s, e, mant[22:0]};
    endfunction

    // Converter model: result appears LAT edges after cv_x is sampled.
    always @(posedge clk) begin
        cvp[0] <= int2f(bus.cv_x);
        for (int i = 1; i < LAT; i++) cvp[i] <= cvp[i-1];
    end
    assign bus.cv_y = cvp[LAT-1];

    // Scoreboard: push on accept, pop and compare on response.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            checks++;
            if (bus.req0_ready && bus.req1_ready) begin
                errors++;
                $display("FAIL double_grant both readies high");
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra got y=%h tag=%0d, none expected",
                             bus.rsp_y, bus.rsp_tag);
                end else begin
                    e = sb.pop_front();
                    if (bus.rsp_y !== e.y || bus.rsp_tag !== e.tag ||
                        bus.rsp_src !== e.src) begin
                        errors++;
                        $display("FAIL sb_data got %h/%0d/%0d want %h/%0d/%0d",
                                 bus.rsp_y, bus.rsp_tag, bus.rsp_src,
                                 e.y, e.tag, e.src);
                    end
                end
            end
            if (bus.req0_ready)
                sb.push_back('{int2f(bus.req0_x), bus.req0_tag, 1'b0});
            if (bus.req1_ready)
                sb.push_back('{int2f(bus.req1_x), bus.req1_tag, 1'b1});
        end
    end

    task automatic drain(input string nm);
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !bus.rsp_valid) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain left=%0d want 0", nm, sb.size());
        end
    endtask

    task automatic send_one(input bit p, input logic [31:0] x,
                            input logic [3:0] t);
        bit ok = 0;
        @(posedge clk); #1;
        if (p) begin
            bus.req1_valid = 1'b1; bus.req1_x = x; bus.req1_tag = t;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_x = x; bus.req0_tag = t;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (p ? bus.req1_ready : bus.req0_ready) ok = 1;
            @(posedge clk); #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout port=%0d accepted=0 want 1", p);
        end
    endtask

    task automatic expect_rsp(input string nm, input logic [31:0] y,
                              input logic [3:0] t, input logic s);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                got = 1;
                checks++;
                if (bus.rsp_y !== y || bus.rsp_tag !== t ||
                    bus.rsp_src !== s) begin
                    errors++;
                    $display("FAIL %s got %h/%0d/%0d want %h/%0d/%0d", nm,
                             bus.rsp_y, bus.rsp_tag, bus.rsp_src, y, t, s);
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout rsp_valid=0 want 1", nm);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_x     = 32'd5;
        bus.req0_tag   = 4'd3;
        bus.req1_valid = 1'b0;
        bus.req1_x     = 32'h0;
        bus.req1_tag   = 4'd0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
                bus.rsp_valid !== 1'b0 || bus.cv_x !== 32'h0) begin
                errors++;
                $display("FAIL reset_state rdy=%b%b vld=%b cvx=%h want 0",
                         bus.req0_ready, bus.req1_ready,
                         bus.rsp_valid, bus.cv_x);
            end
        end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.cv_x !== 32'd5) begin
            errors++;
            $display("FAIL first_cycle_grant rdy=%b cvx=%h want 1/5",
                     bus.req0_ready, bus.cv_x);
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early rsp_valid=%b want 0", bus.rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 32'h40A00000 ||
            bus.rsp_tag !== 4'd3 || bus.rsp_src !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp got %b/%h/%0d/%0d want 1/40a00000/3/0",
                     bus.rsp_valid, bus.rsp_y, bus.rsp_tag, bus.rsp_src);
        end
        drain("single");
    endtask

    task automatic test_boundary();
        send_one(1'b0, 32'h80000000, 4'd1);
        expect_rsp("bnd_min", 32'hCF000000, 4'd1, 1'b0);
        send_one(1'b1, 32'h00000000, 4'd2);
        expect_rsp("bnd_zero", 32'h00000000, 4'd2, 1'b1);
        send_one(1'b0, 32'h7FFFFFFF, 4'd3);
        expect_rsp("bnd_max", 32'h4F000000, 4'd3, 1'b0);
        drain("boundary");
    endtask

    task automatic test_arbitration();
        logic g0, g1, prev1;
        prev1 = 1'b0;
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_x = 32'hFFFFFFFF; bus.req0_tag = 4'd1;
        bus.req1_valid = 1'b1; bus.req1_x = 32'd1;        bus.req1_tag = 4'd2;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            g0 = bus.req0_ready;
            g1 = bus.req1_ready;
            checks++;
            if ((g0 ^ g1) !== 1'b1) begin
                errors++;
                $display("FAIL arb_throughput cyc=%0d grants=%b%b want one",
                         i, g0, g1);
            end
`ifdef FCONV_RR_EN
            if (i > 0) begin
                checks++;
                if (g1 === prev1) begin
                    errors++;
                    $display("FAIL arb_rr cyc=%0d g1=%b want %b",
                             i, g1, !prev1);
                end
            end
`else
            checks++;
            if (g0 !== 1'b1 || g1 !== 1'b0) begin
                errors++;
                $display("FAIL arb_fixed cyc=%0d grants=%b%b want 10",
                         i, g0, g1);
            end
`endif
            prev1 = g1;
            @(posedge clk); #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain("arb");
    endtask

    task automatic test_back_to_back();
        logic [31:0] items [6];
        int idx = 0;
        for (int k = 0; k < 6; k++) items[k] = 32'(10 * k - 20);
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 50 && idx < 6; c++) begin
            @(posedge clk); #1;
            if (c == 10) bus.rsp_ready = 1'b1;
            bus.req1_valid = 1'b1;
            bus.req1_x     = items[idx];
            bus.req1_tag   = 4'(idx);
            @(negedge clk);
            if (c == 9) begin
                checks++;
                if (idx != 3 || bus.req1_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_credit accepted=%0d rdy=%b want 3/0",
                             idx, bus.req1_ready);
                end
            end
            if (bus.req1_ready) idx++;
        end
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        checks++;
        if (idx != 6) begin
            errors++;
            $display("FAIL bp_total accepted=%0d want 6", idx);
        end
        drain("bp");
    endtask

    task automatic test_hold();
        bit seen = 0;
        bus.rsp_ready = 1'b0;
        send_one(1'b1, 32'hFFFFFFF9, 4'd9);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 32'hC0E00000 ||
                bus.rsp_tag !== 4'd9 || bus.rsp_src !== 1'b1) begin
                errors++;
                $display("FAIL hold cyc=%0d got %b/%h/%0d/%0d want 1/c0e00000/9/1",
                         i, bus.rsp_valid, bus.rsp_y, bus.rsp_tag, bus.rsp_src);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        drain("hold");
    endtask

    task automatic test_reset_mid();
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bus.req0_valid = 1'b1;
            bus.req0_x     = 32'(100 + k);
            bus.req0_tag   = 4'(k);
            @(negedge clk);
            checks++;
            if (bus.req0_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_fill k=%0d rdy=%b want 1", k, bus.req0_ready);
            end
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_during rsp_valid=%b want 0", bus.rsp_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_after rsp_valid=%b want 0", bus.rsp_valid);
        end
        bus.rsp_ready = 1'b1;
        send_one(1'b0, 32'd42, 4'd5);
        expect_rsp("rst_fresh", 32'h42280000, 4'd5, 1'b0);
        drain("rst_mid");
        repeat (4) @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_stale rsp_valid=%b want 0", bus.rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_arbitration();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
